alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised successor to the single-cycle integer ALU. It executes the RV base integer ALU operations and the M-extension multiply/divide family behind a valid/ready handshake, so the execute stage can stall on long operations. Base operations complete in one cycle; multiply and divide use a radix-2 iterative datapath with a fixed, width-dependent latency. The unit sits in the execute stage beside the branch comparator. It holds one operation in flight and supports a pipeline kill.

## Interface
- XLEN, 32: operand/result width; power of two, 8..64.
- SHW, log2(XLEN): shift-amount width (derived, not overridden).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- fn  in  5  operation code (see Operation).
- oper1  in  XLEN  first operand (rs1).
- oper2  in  XLEN  second operand (rs2/imm).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- alu_out  out  XLEN  result, held stable while out_valid && !out_ready.
- busy  out  1  multiply/divide iteration in progress.
- kill  in  1  abort in-flight or pending operation.

## Operation
- fn encodings:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR.
  - 7 SL, 8 SR, 9 SRA.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU.
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18..31 execute as ADD.
- Arithmetic and result-width rules:
  - All operands unsigned bit vectors; SLT, SRA, MULH, MULHSU, DIV and REM interpret them two's-complement. MULHSU: oper1 signed, oper2 unsigned.
  - Shifts use oper2[SHW-1:0] only.
  - SLT/SLTU return 1 or 0, zero-extended.
  - ADD/SUB wrap modulo 2^XLEN.
  - MUL returns the low XLEN bits of the 2·XLEN product; MULH* return the high XLEN bits.
- Divide corner cases:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = oper1.
  - Signed overflow (oper1 = 2^(XLEN-1), oper2 = all ones): DIV = oper1, REM = 0.
- FSM states:
  - IDLE: in_ready=1. Accept on in_valid && in_ready. fn 0..9 or 18..31 → DONE with the result registered. fn 10..17 → ITER, with operand magnitudes and sign flags latched.
  - ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, XLEN steps counted by a SHW+1-bit counter. Last step → FIX. busy=1.
  - FIX: apply sign correction and the corner-case overrides, then register the result → DONE. busy=1.
  - DONE: out_valid=1. out_ready=1 → IDLE. out_ready=0 → stay in DONE and hold alu_out.
- in_ready is 1 in IDLE, and in DONE when out_ready=1 (back-to-back accept). A request accepted in DONE enters DONE or ITER next cycle, exactly as from IDLE.
- Kill:
  - kill=1 in any state forces IDLE next cycle; out_valid drops next cycle and no result is delivered.
  - kill=1 overrides in_valid in the same cycle: nothing is accepted.
- Reset:
  - Asserting rst forces state IDLE immediately, including mid-iteration.
  - Reset values: in_ready=1 (combinational from IDLE), out_valid=0, busy=0, alu_out=0, iteration counter=0.

## Timing
- Base op: accepted at edge N → out_valid=1 after edge N+1 (latency 1).
- Mul/div: accepted at edge N → ITER for XLEN cycles, FIX for 1 cycle → out_valid after edge N+XLEN+2 (34 cycles for XLEN=32).
- Latency is data-independent; there is no early termination.
- Throughput with out_ready held high:
  - base ops: one result per cycle;
  - mul/div: one result per XLEN+2 cycles.
- No combinational path from in_valid, oper1 or oper2 to any output. in_ready depends combinationally on out_ready, kill and state.

## Test plan
- Base ops, XLEN=32, out_ready=1, back-to-back:
  - ADD 0xFFFFFFFF+1 → 0;
  - SLT 0xFFFFFFFF,1 → 1; SLTU → 0;
  - SRA 0x80000000 by oper2=0x21 → 0xC0000000 (shamt=1);
  - one result per cycle, in_ready held high.
- Multiply: oper1=0xFFFFFFFF, oper2=2:
  - MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF; MULHU → 0x00000001; MULHSU → 0xFFFFFFFF;
  - each out_valid exactly 34 cycles after accept; busy high for cycles 1..33.
- Divide corners:
  - DIV 7,0 → 0xFFFFFFFF; REMU 7,0 → 7;
  - DIV 0x80000000,0xFFFFFFFF → 0x80000000; REM of the same → 0;
  - DIV −7,2 → −3 (0xFFFFFFFD); REM −7,2 → −1.
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles:
  - out_valid and alu_out=7 held stable; in_ready=0 throughout;
  - raising out_ready together with a new in_valid accepts the next request in the same cycle.
- Kill: start DIVU, assert kill at iteration 10:
  - IDLE next cycle; out_valid never rises for the killed op;
  - a following ADD 1+1 returns 2 with latency 1.
- Reset mid-operation: assert rst during ITER of MUL:
  - out_valid, busy and alu_out read 0 before the next clock edge; in_ready=1;
  - after deassertion a MULHU 0x10000,0x10000 returns 1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV integer ALU. Base operations finish in one cycle.
// MUL/MULH*/DIV*/REM* run on a shared radix-2 iterative datapath with a
// fixed latency of XLEN+2 cycles from accept to result.
module alu_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      fn,
  input  logic [XLEN-1:0] oper1,
  input  logic [XLEN-1:0] oper2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy,
  input  logic            kill
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [SHW:0]      LAST_STEP = (SHW+1)'(XLEN-1);
  localparam logic [SHW:0]      CNT_ONE   = (SHW+1)'(1);
  localparam logic [XLEN-1:0]   ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] FN_ADD    = 5'd0;
  localparam logic [4:0] FN_SUB    = 5'd1;
  localparam logic [4:0] FN_SLT    = 5'd2;
  localparam logic [4:0] FN_SLTU   = 5'd3;
  localparam logic [4:0] FN_AND    = 5'd4;
  localparam logic [4:0] FN_OR     = 5'd5;
  localparam logic [4:0] FN_XOR    = 5'd6;
  localparam logic [4:0] FN_SL     = 5'd7;
  localparam logic [4:0] FN_SR     = 5'd8;
  localparam logic [4:0] FN_SRA    = 5'd9;
  localparam logic [4:0] FN_MUL    = 5'd10;
  localparam logic [4:0] FN_MULH   = 5'd11;
  localparam logic [4:0] FN_MULHSU = 5'd12;
  localparam logic [4:0] FN_MULHU  = 5'd13;
  localparam logic [4:0] FN_DIV    = 5'd14;
  localparam logic [4:0] FN_DIVU   = 5'd15;
  localparam logic [4:0] FN_REM    = 5'd16;
  localparam logic [4:0] FN_REMU   = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Iterative datapath state: acc holds {hi, lo} of the running product or
  // {remainder, quotient} of the division; opnd is multiplicand or divisor.
  logic [SHW:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              div_q, div_d;
  logic              hi_q, hi_d;
  logic              rem_q, rem_d;
  logic              neg_q, neg_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              accept;
  logic              is_md;
  logic              is_div_op;
  logic              want_rem_op;
  logic              want_hi_op;
  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_mag;
  logic [XLEN-1:0]   fix_res;

  assign accept  = in_valid && in_ready;
  assign alu_out = res_q;

  // Classify the incoming request and form operand magnitudes and sign flags
  always_comb begin
    is_md       = (fn >= FN_MUL) && (fn <= FN_REMU);
    is_div_op   = (fn >= FN_DIV) && (fn <= FN_REMU);
    want_rem_op = (fn == FN_REM) || (fn == FN_REMU);
    want_hi_op  = (fn == FN_MULH) || (fn == FN_MULHSU) || (fn == FN_MULHU);
    a_signed    = (fn == FN_MULH) || (fn == FN_MULHSU) || (fn == FN_DIV) || (fn == FN_REM);
    b_signed    = (fn == FN_MULH) || (fn == FN_DIV) || (fn == FN_REM);
    a_neg       = a_signed && oper1[XLEN-1];
    b_neg       = b_signed && oper2[XLEN-1];
    a_mag       = a_neg ? (-oper1) : oper1;
    b_mag       = b_neg ? (-oper2) : oper2;
  end

  // Single-cycle result for the base operations; unused codes behave as ADD
  always_comb begin
    shamt = oper2[SHW-1:0];
    case (fn)
      FN_SUB:  base_res = oper1 - oper2;
      FN_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(oper1) < $signed(oper2))};
      FN_SLTU: base_res = {{(XLEN-1){1'b0}}, (oper1 < oper2)};
      FN_AND:  base_res = oper1 & oper2;
      FN_OR:   base_res = oper1 | oper2;
      FN_XOR:  base_res = oper1 ^ oper2;
      FN_SL:   base_res = oper1 << shamt;
      FN_SR:   base_res = oper1 >> shamt;
      FN_SRA:  base_res = $signed(oper1) >>> shamt;
      default: base_res = oper1 + oper2;
    endcase
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for
  // divide. A set top bit of div_diff means the trial subtraction borrowed.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                        : {1'b0, acc_q[2*XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, opnd_q};
    div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction and divide corner-case overrides applied in FIX
  always_comb begin
    prod_fix = neg_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
    div_mag  = rem_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (div_q) begin
      fix_res = neg_q ? (-div_mag) : div_mag;
      if (dz_q && !rem_q) begin
        fix_res = ALL_ONES;
      end
      if (ovf_q) begin
        fix_res = rem_q ? {XLEN{1'b0}} : MIN_INT;
      end
    end else begin
      fix_res = hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  // State register; reset aborts any iteration immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; kill wins over everything, including a new request
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = is_md ? ITER : DONE;
    end else begin
      case (state_q)
        ITER:    if (cnt_q == LAST_STEP) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    in_ready  = !kill && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    out_valid = (state_q == DONE);
    busy      = (state_q == ITER) || (state_q == FIX);
  end

  // Datapath next values: latch on accept, step in ITER, finalise in FIX
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    hi_d   = hi_q;
    rem_d  = rem_q;
    neg_d  = neg_q;
    dz_d   = dz_q;
    ovf_d  = ovf_q;
    res_d  = res_q;
    if (accept) begin
      cnt_d = '0;
      if (!is_md) begin
        res_d = base_res;
      end else begin
        acc_d  = {{XLEN{1'b0}}, (is_div_op ? a_mag : b_mag)};
        opnd_d = is_div_op ? b_mag : a_mag;
        div_d  = is_div_op;
        hi_d   = want_hi_op;
        rem_d  = want_rem_op;
        neg_d  = want_rem_op ? a_neg : (a_neg ^ b_neg);
        dz_d   = (oper2 == {XLEN{1'b0}});
        ovf_d  = ((fn == FN_DIV) || (fn == FN_REM)) && (oper1 == MIN_INT) && (oper2 == ALL_ONES);
      end
    end else if (state_q == ITER) begin
      acc_d = div_q ? div_next : mul_next;
      cnt_d = cnt_q + CNT_ONE;
    end else if (state_q == FIX) begin
      res_d = fix_res;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
      rem_q  <= 1'b0;
      neg_q  <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      rem_q  <= rem_d;
      neg_q  <= neg_d;
      dz_q   <= dz_d;
      ovf_q  <= ovf_d;
      res_q  <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc. Accepted requests push their
// expected result and latency; a negedge monitor compares whatever the DUT
// presents against the head of the queue.
module tb_alu_mc;

  localparam int XLEN = 32;

  localparam logic [4:0] F_ADD = 5'd0,  F_SUB = 5'd1,  F_SLT = 5'd2,  F_SLTU = 5'd3;
  localparam logic [4:0] F_AND = 5'd4,  F_OR = 5'd5,   F_XOR = 5'd6,  F_SL = 5'd7;
  localparam logic [4:0] F_SR = 5'd8,   F_SRA = 5'd9,  F_MUL = 5'd10, F_MULH = 5'd11;
  localparam logic [4:0] F_MULHSU = 5'd12, F_MULHU = 5'd13, F_DIV = 5'd14, F_DIVU = 5'd15;
  localparam logic [4:0] F_REM = 5'd16, F_REMU = 5'd17;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      fn;
  logic [XLEN-1:0] oper1;
  logic [XLEN-1:0] oper2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_out;
  logic            busy;
  logic            kill;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fn        (fn),
    .oper1     (oper1),
    .oper2     (oper2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .busy      (busy),
    .kill      (kill)
  );

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
    logic [4:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_mode = 0;
  bit   have_first = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the operation rules
  function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic [4:0]      sh;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sh  = b[4:0];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      F_SUB:    return a - b;
      F_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      F_SLT+5'd1: return (ua < ub) ? 32'd1 : 32'd0;
      F_AND:    return a & b;
      F_OR:     return a | b;
      F_XOR:    return a ^ b;
      F_SL:     return a << sh;
      F_SR:     return a >> sh;
      F_SRA:    begin p = 64'(sa >>> sh); return p[31:0]; end
      F_MUL:    begin p = ua * ub; return p[31:0]; end
      F_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      F_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      F_MULHU:  begin p = ua * ub; return p[63:32]; end
      F_DIV:    begin
                  if (b == 0) return 32'hFFFF_FFFF;
                  if (ovf) return a;
                  p = 64'(sa / sb); return p[31:0];
                end
      F_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM:    begin
                  if (b == 0) return a;
                  if (ovf) return 32'd0;
                  p = 64'(sa % sb); return p[31:0];
                end
      F_REMU:   return (b == 0) ? a : a % b;
      default:  return a + b;
    endcase
  endfunction

  function automatic int expLatency(input logic [4:0] f);
    return ((f >= F_MUL) && (f <= F_REMU)) ? XLEN + 2 : 1;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Drive a request from posedge+1 and hold it until it is accepted; the
  // expected response is queued when acceptance is seen (push=1).
  task automatic applyStimulus(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                               input bit push, output int waits);
    exp_t e;
    in_valid = 1'b1;
    fn       = f;
    oper1    = a;
    oper2    = b;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) break;
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (waits > 200) begin
      checkOutput("accept timeout", 32'(waits), 32'd0);
    end else if (push) begin
      e.res     = model(f, a, b);
      e.acc_cyc = cyc + 1;
      e.lat     = expLatency(f);
      e.f       = f;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Issue a multiply/divide and count the busy cycles before out_valid
  task automatic runMulDiv(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    int w;
    int busy_cnt;
    int guard;
    applyStimulus(f, a, b, 1'b1, w);
    busy_cnt = 0;
    guard    = 0;
    while (guard < 100) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) busy_cnt++;
      guard++;
    end
    checkOutput("busy cycle count", 32'(busy_cnt), 32'(XLEN + 1));
    checkOutput("busy low at done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented result is compared with the queue head; the
  // first cycle it appears also checks latency, and a handshake pops it.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious out_valid", {31'd0, out_valid}, 32'd0);
      end else if (out_valid) begin
        if (!have_first) begin
          have_first = 1'b1;
          checkOutput($sformatf("latency fn=%0d", exp_q[0].f),
                      32'(cyc - exp_q[0].acc_cyc + 1), 32'(exp_q[0].lat));
        end
        checkOutput($sformatf("result fn=%0d", exp_q[0].f), alu_out, exp_q[0].res);
        if (out_ready) begin
          void'(exp_q.pop_front());
          have_first = 1'b0;
        end
      end
    end
  end

  initial begin
    int w;
    int c0;
    int guard;
    logic [4:0] rf;
    rst       = 1'b1;
    in_valid  = 1'b0;
    fn        = '0;
    oper1     = '0;
    oper2     = '0;
    out_ready = 1'b1;
    kill      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset alu_out", alu_out, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back base ops, one per cycle
    c0 = cyc;
    applyStimulus(F_ADD,  32'hFFFF_FFFF, 32'h1,  1'b1, w);
    applyStimulus(F_SLT,  32'hFFFF_FFFF, 32'h1,  1'b1, w);
    applyStimulus(F_SLTU, 32'hFFFF_FFFF, 32'h1,  1'b1, w);
    applyStimulus(F_SRA,  32'h8000_0000, 32'h21, 1'b1, w);
    checkOutput("base throughput cycles", 32'(cyc - c0), 32'd4);
    @(posedge clk);
    #1;

    // Multiplies
    runMulDiv(F_MUL,    32'hFFFF_FFFF, 32'h2);
    runMulDiv(F_MULH,   32'hFFFF_FFFF, 32'h2);
    runMulDiv(F_MULHU,  32'hFFFF_FFFF, 32'h2);
    runMulDiv(F_MULHSU, 32'hFFFF_FFFF, 32'h2);

    // Divide corners
    runMulDiv(F_DIV,  32'd7, 32'd0);
    runMulDiv(F_REMU, 32'd7, 32'd0);
    runMulDiv(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    runMulDiv(F_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    runMulDiv(F_DIV,  32'hFFFF_FFF9, 32'd2);
    runMulDiv(F_REM,  32'hFFFF_FFF9, 32'd2);
    runMulDiv(F_REM,  32'hFFFF_FFF9, 32'd0);

    // Backpressure: result held, no accept until out_ready returns
    out_ready = 1'b0;
    applyStimulus(F_ADD, 32'd3, 32'd4, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp out_valid held", {31'd0, out_valid}, 32'd1);
      checkOutput("bp in_ready low", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(F_SUB, 32'd5, 32'd6, 1'b1, w);
    checkOutput("bp same-cycle accept waits", 32'(w), 32'd0);
    @(posedge clk);
    #1;

    // Kill at iteration 10; a request in the kill cycle is ignored
    applyStimulus(F_DIVU, 32'h1234_5678, 32'd3, 1'b0, w);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    kill     = 1'b1;
    in_valid = 1'b1;
    fn       = F_MUL;
    oper1    = 32'd9;
    oper2    = 32'd9;
    @(negedge clk);
    checkOutput("kill in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("busy before kill edge", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    kill     = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("after kill busy", {31'd0, busy}, 32'd0);
    checkOutput("after kill out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("after kill in_ready", {31'd0, in_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(F_ADD, 32'd1, 32'd1, 1'b1, w);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-multiply
    applyStimulus(F_MUL, 32'h0001_2345, 32'h0000_0777, 1'b0, w);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    checkOutput("async reset alu_out", alu_out, 32'd0);
    checkOutput("async reset in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    runMulDiv(F_MULHU, 32'h0001_0000, 32'h0001_0000);

    // Randomized mix with random backpressure
    rand_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      rf = 5'($urandom_range(0, 31));
      applyStimulus(rf, pickOperand(), pickOperand(), 1'b1, w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;

    // Drain outstanding results
    guard = 0;
    while ((exp_q.size() != 0) && (guard < 200)) begin
      @(posedge clk);
      guard++;
    end
    #1;
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
